// File: rtl/irq_ctrl.sv
// irq_ctrl - priority interrupt controller
//
// Collects level-sensitive interrupt requests from peripherals, picks the
// highest-priority pending source (index 0 wins), presents its vector to the
// CPU, pulses exec[idx] for one cycle once the CPU accepts, then holds off all
// further requests until the CPU returns from the interrupt.
//
// Build option:
//   IRQ_MASK_EN  when defined, adds a writable per-source mask register
//                (reset to all ones). When undefined, mask is the constant
//                all ones and mask_we / mask_wdata are ignored.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   req         level interrupt requests, one per source
//   gie         CPU global interrupt enable
//   cpu_ack     CPU accepts the presented interrupt
//   reti        one-cycle return-from-interrupt pulse
//   mask_we     mask register write strobe (IRQ_MASK_EN only)
//   mask_wdata  mask register write data (IRQ_MASK_EN only)
//   irq_valid   an interrupt is presented to the CPU
//   irq_vector  vector of the presented interrupt
//   exec        one-hot, one-cycle acknowledge to the winning source
//   in_service  an interrupt is being serviced
//   mask        current mask register
//
// State table:
//   state   | meaning
//   IDLE    | waiting for an enabled, unmasked request
//   PEND    | winner latched, irq_valid high, waiting for cpu_ack
//   ACK     | exec pulse to the winning source, service begins
//   SERVICE | handler running, requests ignored until reti

module irq_ctrl #(
  parameter int NUM_SRC    = 4,
  parameter int VEC_W      = 8,
  parameter int VEC_BASE   = 'h02,
  parameter int VEC_STRIDE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic               gie,
  input  logic               cpu_ack,
  input  logic               reti,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic               irq_valid,
  output logic [VEC_W-1:0]   irq_vector,
  output logic [NUM_SRC-1:0] exec,
  output logic               in_service,
  output logic [NUM_SRC-1:0] mask
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    ACK     = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_SRC-1:0] eff;
  logic [IDX_W-1:0]   win_idx;
  logic               win_hit;

  // ---------------------------------------------------------------------------
  // Mask register
  // ---------------------------------------------------------------------------
`ifdef IRQ_MASK_EN
  logic [NUM_SRC-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_q <= '1;
    end else if (mask_we) begin
      mask_q <= mask_wdata;
    end
  end

  assign mask = mask_q;
`else
  logic unused_mask_inputs;

  assign unused_mask_inputs = ^{mask_we, mask_wdata};
  assign mask               = '1;
`endif

  assign eff = req & mask;

  // ---------------------------------------------------------------------------
  // Fixed-priority arbitration: lowest set index of eff wins. Scanning from
  // the top down lets the last hit (the lowest index) take precedence.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_idx = '0;
    win_hit = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eff[i]) begin
        win_idx = IDX_W'(i);
        win_hit = 1'b1;
      end
    end
  end

  // Vector arithmetic is done in 32 bits and truncated, so any overflow
  // simply wraps modulo 2^VEC_W.
  function automatic logic [VEC_W-1:0] vec_of(input logic [IDX_W-1:0] idx);
    int v;
    v = VEC_BASE + VEC_STRIDE * int'(idx);
    return VEC_W'(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Controller FSM, all outputs registered
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      idx_q      <= '0;
      irq_valid  <= 1'b0;
      irq_vector <= '0;
      exec       <= '0;
      in_service <= 1'b0;
    end else begin
      exec <= '0;
      case (state)
        IDLE: begin
          if (gie && win_hit) begin
            idx_q      <= win_idx;
            irq_vector <= vec_of(win_idx);
            irq_valid  <= 1'b1;
            state      <= PEND;
          end
        end

        PEND: begin
          // Acceptance wins over a same-cycle withdrawal or gie drop: the CPU
          // has already committed to the vector it saw.
          if (cpu_ack) begin
            irq_valid  <= 1'b0;
            exec       <= NUM_SRC'(1) << idx_q;
            in_service <= 1'b1;
            state      <= ACK;
          end else if (!eff[idx_q] || !gie) begin
            irq_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        ACK: begin
          state <= SERVICE;
        end

        SERVICE: begin
          if (reti) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          irq_valid  <= 1'b0;
          in_service <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
